// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the data-memory arbiter.
//   - default address/data/index widths
//   - requester port indices
//   - rsp_t: one-cycle response record captured when an access is accepted
package dmem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int IDX_W_DEF  = 16;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   typedef struct packed {
      logic valid;  // an access was accepted last cycle
      logic port;   // which requester owns the response
      logic rd;     // access was a read
      logic err;    // address was out of range, memory not touched
   } rsp_t;

endpackage

// File: rtl/dmem_prio_sel.sv
// dmem_prio_sel: two-way grant logic with a bounded port-0 streak.
//   clk, rst_n      clock, async active-low reset
//   req0_valid      CPU request (already qualified by reset)
//   req1_valid      loader/debug request (already qualified by reset)
//   gnt0, gnt1      one-hot (or zero) grant, combinational
// Port 0 normally wins a tie; after MAX_STREAK consecutive port-0 grants
// with port 1 waiting, port 1 is forced through once.
module dmem_prio_sel #(
   parameter int MAX_STREAK = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0_valid,
   input  logic req1_valid,
   output logic gnt0,
   output logic gnt1
);

   logic [3:0] streak;
   logic       at_max;

   assign at_max = (streak == 4'(MAX_STREAK));
   assign gnt1   = req1_valid && (!req0_valid || at_max);
   assign gnt0   = req0_valid && !gnt1;

   // Streak only measures how long port 1 has been kept waiting, so it
   // resets whenever port 1 is not asking or has just been served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         streak <= '0;
      else if (!req1_valid || gnt1)
         streak <= '0;
      else if (gnt0 && !at_max)
         streak <= streak + 4'd1;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU (port 0)
// and the loader/debug port (port 1). One access per clock, no wait states,
// one-cycle response for every accepted access (reads, writes, errors).
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/we/addr/wdata        request from port N
//   reqN_ready                      port N accepted this cycle
//   rspN_valid/rdata/err            response for the access accepted last cycle
//   mem_rd/wrt/addr/datain          memory command
//   mem_dataout                     memory read data, valid cycle after mem_rd
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int IDX_W      = IDX_W_DEF,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   input  logic              req1_valid,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic              mem_rd,
   output logic              mem_wrt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout
);

   // Requests are masked while reset is held so nothing is accepted or
   // issued to memory until release.
   logic v0, v1;
   logic gnt0, gnt1;
   assign v0 = req0_valid && rst_n;
   assign v1 = req1_valid && rst_n;

   dmem_prio_sel #(.MAX_STREAK(MAX_STREAK)) u_sel (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (v0),
      .req1_valid (v1),
      .gnt0       (gnt0),
      .gnt1       (gnt1)
   );

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Mux the granted request onto a single command.
   logic              acc;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              oor;
   logic              issue;

   assign acc       = gnt0 || gnt1;
   assign sel_we    = gnt1 ? req1_we    : req0_we;
   assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
   assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;
   assign oor       = (sel_addr >> IDX_W) != '0;
   assign issue     = acc && !oor;

   assign mem_rd     = issue && !sel_we;
   assign mem_wrt    = issue &&  sel_we;
   assign mem_addr   = issue ? sel_addr  : '0;
   assign mem_datain = issue ? sel_wdata : '0;

   // Response record; async reset drops any in-flight response.
   rsp_t pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
      end else begin
         pend.valid <= acc;
         pend.port  <= gnt1 ? PORT_LDR : PORT_CPU;
         pend.rd    <= acc && !sel_we;
         pend.err   <= acc && oor;
      end
   end

   logic [DATA_W-1:0] rd_data;
   logic              own0, own1;

   assign rd_data = (pend.rd && !pend.err) ? mem_dataout : '0;
   assign own0    = pend.valid && (pend.port == PORT_CPU);
   assign own1    = pend.valid && (pend.port == PORT_LDR);

   assign rsp0_valid = own0;
   assign rsp0_err   = own0 && pend.err;
   assign rsp0_rdata = own0 ? rd_data : '0;
   assign rsp1_valid = own1;
   assign rsp1_err   = own1 && pend.err;
   assign rsp1_rdata = own1 ? rd_data : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (synchronous write, registered read, 64K x 32 words indexed by addr[15:0]) between two requesters.
- Port 0 is the CPU load/store stage. Port 1 is the program/data loader or debug port.
- Issues at most one access per clock, drives the memory's rd/wrt/addr/datain, and returns read data with a one-cycle response.
- Prevents CPU starvation of the loader with a bounded-streak priority scheme.

Parameters:
- ADDR_W, 32, requester and memory address width.
- DATA_W, 32, data width.
- IDX_W, 16, number of low address bits the memory decodes; any set bit above IDX_W-1 is out of range.
- MAX_STREAK, 4, maximum consecutive port-0 grants while port 1 waits (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  word address.
- req0_wdata  in  DATA_W  write data.
- req0_ready  out  1  request accepted this cycle.
- rsp0_valid  out  1  response for an accepted port 0 access.
- rsp0_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp0_err  out  1  address out of range.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0.
- mem_rd  out  1  to memory rd.
- mem_wrt  out  1  to memory wrt.
- mem_addr  out  ADDR_W  to memory addr.
- mem_datain  out  DATA_W  to memory datain.
- mem_dataout  in  DATA_W  from memory dataout, valid the cycle after mem_rd.

Behaviour:
- Reset (async assert, sync release):
  - streak counter = 0; pend_port = 0; pend_rd = 0; pend_err = 0.
  - All rsp*_valid = 0 and rsp*_err = 0.
  - req*_ready = 0 and mem_rd = mem_wrt = 0 while rst_n is low.
- Arbitration (combinational, every cycle):
  - Only one valid: that port is granted.
  - Both valid: port 0 wins unless streak == MAX_STREAK, in which case port 1 wins.
- Streak counter (registered):
  - Increments on a port-0 grant while req1_valid = 1, saturating at MAX_STREAK.
  - Clears on any port-1 grant, and on any cycle where req1_valid = 0.
- Granted port:
  - reqN_ready = 1 in the same cycle. The transfer occurs when valid && ready; there are no wait states, so back-to-back accesses run at full rate.
  - The ungranted port's ready = 0. It must hold valid/addr/we/wdata stable until it sees ready.
- Out-of-range address (any bit above IDX_W-1 set):
  - Accepted with ready = 1 but not issued: mem_rd = mem_wrt = 0.
  - Next cycle: rspN_valid = 1, rspN_err = 1, rspN_rdata = 0.
- In-range access:
  - mem_addr = addr, mem_datain = wdata.
  - mem_wrt = we, mem_rd = !we.
- Response pipeline (1 cycle):
  - Registers pend_valid, pend_port, pend_rd, pend_err on acceptance.
  - Next cycle: rsp[pend_port]_valid = 1 for exactly one cycle.
  - rdata = mem_dataout if pend_rd && !pend_err, else 0.
  - Writes also produce a response (write acknowledge).
- Idle cycle: mem_rd = mem_wrt = 0. mem_addr and mem_datain are don't-care; drive 0.
- Same address, write followed by read: the read on the next cycle returns the new data. No forwarding is needed because the write commits at the earlier edge.
- Reset mid-operation: a pending response is discarded. No rsp is produced after rst_n deasserts for an access accepted before reset.

Decomposition:
- Package dmem_pkg: ADDR_W/DATA_W/IDX_W defaults, port-index constants PORT_CPU = 0 and PORT_LDR = 1, and a response struct {valid, port, rd, err}.
- One natural sub-module, dmem_prio_sel: the combinational grant logic plus the streak counter register. The top level holds the response register and the muxes.

Test Plan:
- Port 0 write addr 0x10 = 0xDEADBEEF, then read 0x10 -> req0_ready = 1 both cycles; rsp0_valid each following cycle; rsp0_rdata = 0xDEADBEEF on the read response.
- Both ports request continuously with MAX_STREAK = 4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; port 1 is never waiting more than 4 cycles.
- Port 1 reads addr 0x0001_0000 -> ready = 1, mem_rd = 0, next cycle rsp1_valid = 1, rsp1_err = 1, rsp1_rdata = 0.
- Port 0 writes 0x20 = 5; the same cycle port 1 requests a read of 0x20 -> port 1 is stalled, then granted next cycle and reads 5.
- Reset asserted the cycle after a port 0 read of 0x10 is accepted -> no rsp0_valid after release; all outputs are 0 during reset.
- Port 1 alone streams 8 reads 0x0..0x7 preloaded with i*3 -> 8 consecutive responses with rdata 0,3,...,21; the streak counter stays 0.
